uart_tx_scheduler: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/uart_tx_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART TX scheduling path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_BYTE_W = 8;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = c_ST_IDLE,
        ISSUE = c_ST_ISSUE,
        WAIT  = c_ST_WAIT,
        GAP   = c_ST_GAP
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first asserted request at or
//               after the pointer, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [IDX_W-1:0]   ptr_in,
    output logic [NUM_REQ-1:0] grant_oh_out,
    output logic [IDX_W-1:0]   grant_idx_out,
    output logic               grant_valid_out
);

    int               w_sum;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        grant_oh_out    = '0;
        grant_idx_out   = '0;
        grant_valid_out = 1'b0;
        w_sum           = 0;
        w_idx           = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = int'(ptr_in) + i;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_idx = IDX_W'(w_sum);
            if (!grant_valid_out && req_in[w_idx]) begin
                grant_valid_out      = 1'b1;
                grant_idx_out        = w_idx;
                grant_oh_out[w_idx]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Packet-granular round-robin sharing of one UART transmitter
//               among NUM_REQ byte-stream requesters, with gap and stall abort.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int GAP_CYCLES    = 0,
    parameter int STALL_TIMEOUT = 1_000_000
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [NUM_REQ-1:0]                req_valid_in,
    input  logic [NUM_REQ-1:0][c_BYTE_W-1:0]  req_data_in,
    input  logic [NUM_REQ-1:0]                req_last_in,
    output logic [NUM_REQ-1:0]                req_ready_out,
    output logic                              tx_trigger_out,
    output logic [c_BYTE_W-1:0]               tx_data_out,
    input  logic                              tx_busy_in,
    output logic [$clog2(NUM_REQ)-1:0]        grant_out,
    output logic                              active_out,
    output logic                              abort_out
);

    localparam int c_IDX_W     = $clog2(NUM_REQ);
    localparam int c_STALL_W   = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam int c_GAP_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam bit c_ABORT_EN  = (STALL_TIMEOUT > 0);

    sched_state_t           r_state;
    logic [c_IDX_W-1:0]     r_grant;
    logic [NUM_REQ-1:0]     r_grant_oh;
    logic [c_IDX_W-1:0]     r_rr_ptr;
    logic                   r_last;
    logic                   r_mid;
    logic [c_STALL_W-1:0]   r_stall_cnt;
    logic [c_GAP_W-1:0]     r_gap_cnt;

    logic [NUM_REQ-1:0]     w_arb_oh;
    logic [c_IDX_W-1:0]     w_arb_idx;
    logic                   w_arb_valid;
    logic                   w_sel_valid;
    logic [c_BYTE_W-1:0]    w_sel_data;
    logic                   w_sel_last;
    logic                   w_fire;
    logic                   w_stall;
    logic                   w_abort;
    logic [c_IDX_W-1:0]     w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_arbiter (
        .req_in          (req_valid_in),
        .ptr_in          (r_rr_ptr),
        .grant_oh_out    (w_arb_oh),
        .grant_idx_out   (w_arb_idx),
        .grant_valid_out (w_arb_valid)
    );

    always_comb begin
        w_sel_valid = req_valid_in[r_grant];
        w_sel_data  = req_data_in[r_grant];
        w_sel_last  = req_last_in[r_grant];
        w_fire      = (r_state == ISSUE) && w_sel_valid && !tx_busy_in;
        // Only a packet with at least one byte already sent can stall.
        w_stall     = (r_state == ISSUE) && !w_sel_valid && r_mid;
        w_abort     = c_ABORT_EN && w_stall &&
                      (r_stall_cnt == c_STALL_W'(STALL_TIMEOUT - 1));
        w_ptr_next  = (r_grant == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    end

    assign tx_trigger_out = w_fire;
    assign req_ready_out  = w_fire ? r_grant_oh : '0;
    assign tx_data_out    = (r_state == ISSUE) ? w_sel_data : '0;
    assign active_out     = (r_state == ISSUE) || (r_state == WAIT);
    assign abort_out      = w_abort;
    assign grant_out      = r_grant;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_oh  <= '0;
            r_rr_ptr    <= '0;
            r_last      <= 1'b0;
            r_mid       <= 1'b0;
            r_stall_cnt <= '0;
            r_gap_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_grant     <= w_arb_idx;
                        r_grant_oh  <= w_arb_oh;
                        r_mid       <= 1'b0;
                        r_stall_cnt <= '0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_fire) begin
                        r_last      <= w_sel_last;
                        r_mid       <= 1'b1;
                        r_stall_cnt <= '0;
                        r_state     <= WAIT;
                    end else if (w_abort) begin
                        r_rr_ptr    <= w_ptr_next;
                        r_mid       <= 1'b0;
                        r_stall_cnt <= '0;
                        r_state     <= IDLE;
                    end else if (w_stall && c_ABORT_EN) begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (!tx_busy_in) begin
                        if (r_last) begin
                            r_rr_ptr <= w_ptr_next;
                            r_mid    <= 1'b0;
                            r_state  <= (GAP_CYCLES > 0) ? GAP : IDLE;
                        end else begin
                            r_state  <= ISSUE;
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == c_GAP_W'(GAP_CYCLES - 1)) begin
                        r_gap_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
